uart_tx_port: RTL
=================

# uart_tx_port

Memory-mapped UART transmitter that acts as a bus responder for the single-cycle processor's peripheral bus. Software writes bytes to a data register. The block queues them in a small FIFO and serializes them as 8N1 frames on `tx`. It raises a level interrupt when the queue drains. Its `rdata` returns zero for unmapped addresses, so it can be OR-combined with the other peripheral and data-memory read buses.

## Interface
- `CLKS_PER_BIT`, 5208: clk cycles per UART bit (50 MHz / 9600 baud); legal range ≥ 2.
- `FIFO_DEPTH`, 4: TX queue depth; must be a power of two.
- `DATA_ADDR`, 32'h40000018: write-only TX data register.
- `STAT_ADDR`, 32'h4000001C: status (read) and clear (write) register.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low.
- `rd`  in  1  bus read strobe.
- `wr`  in  1  bus write strobe; sampled at posedge clk.
- `addr`  in  32  byte address.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data; combinational.
- `tx`  out  1  serial output; idle high.
- `irq`  out  1  level interrupt; tx-done pending.

## Operation
- `wr && addr==DATA_ADDR`: push `wdata[7:0]`.
  - If the FIFO is full (pre-edge count), the byte is dropped and `overflow` is set.
  - Full is evaluated before any same-cycle pop, so a push into a full FIFO is rejected even if a pop occurs that edge.
- `wr && addr==STAT_ADDR`:
  - `wdata[0]=1` clears `irq_pend`.
  - `wdata[1]=1` clears `overflow`.
- `rd && addr==STAT_ADDR`: `rdata = {27'b0, irq_pend, overflow, busy, full, empty}` (bits 4..0). All other cases give `rdata = 0`. Reads have no side effects.
- FSM states IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, zero the bit counter, and go to START.
  - START: `tx=0` for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `tx=shift[0]`. Shift right every CLKS_PER_BIT cycles. After 8 bits (LSB first), go to STOP.
  - STOP: `tx=1` for CLKS_PER_BIT cycles. At the end, set `irq_pend` if the FIFO is empty. Then go to IDLE if empty; otherwise pop immediately and go to START, with no idle gap.
- `busy` = state ≠ IDLE.
- `irq = irq_pend`.
- If a clear write and a set event happen on the same edge, the set wins.
- `tx` is a register output; it is never driven combinationally from the FSM.

## Timing
- Reset values:
  - `tx=1`, `irq=0`, `rdata=0` (no strobe asserted).
  - FIFO empty, `overflow=0`, state IDLE, baud counter 0.
- Reset asserted mid-frame: `tx` returns high asynchronously and all queued bytes are discarded.
- Write to an empty FIFO in IDLE at edge N:
  - `empty=0` after N.
  - Pop at N+1; `tx` falls after N+1.
- Frame length is exactly 10·CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- `irq` rises on the edge that ends the last stop bit.
- FIFO count wraps correctly across pointer wrap-around; FIFO_DEPTH writes fit without loss when none are popped.

## Structure
- Shared package `uart_tx_pkg` holds:
  - FSM state encoding (2-bit enum: IDLE=0, START=1, DATA=2, STOP=3);
  - status bit indices (EMPTY=0, FULL=1, BUSY=2, OVF=3, IRQ=4);
  - default address constants.
- Sub-module `tx_fifo`: synchronous FIFO parameterized by width (8) and depth, with push, pop, dout, full, empty and async active-low reset.
- Top-level contents: address decode, status register, baud counter, FSM and shift register.

## Test plan
Bench uses CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- Reset: hold `reset=0` 3 cycles → `tx=1`, `irq=0`, status read = 5'b00001.
- Single byte: write 32'h000000A5 to DATA_ADDR → `tx` shows start bit 0, data 1,0,1,0,0,1,0,1, then stop 1, each bit 4 cycles. `irq=1` on the 40th cycle after the pop; status read = 5'b10001.
- Back-to-back: write 0x55, 0x0F, 0x80 on consecutive cycles → three contiguous 40-cycle frames with no idle gap. `irq` is set only after the third stop bit.
- Overflow: write 6 bytes in 6 cycles → first pop frees one slot, so 5 bytes are transmitted and the sixth is dropped. Status `overflow=1`; writing 32'h2 to STAT_ADDR clears it.
- IRQ clear race: write 32'h1 to STAT_ADDR on the edge that completes a stop bit with the FIFO empty → `irq` stays 1. Writing 32'h1 one cycle later → `irq=0`.
- Reset mid-frame: assert `reset` during the DATA state of 0x3C with 2 bytes queued → `tx=1` immediately. After release, `empty=1` and no further frames are sent.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_pkg: shared state encoding, status bit map and address defaults
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;
  localparam int STAT_IRQ   = 4;

  localparam logic [31:0] DEFAULT_DATA_ADDR = 32'h4000_0018;
  localparam logic [31:0] DEFAULT_STAT_ADDR = 32'h4000_001C;

  function automatic logic [31:0] pack_status(input logic irq_pend,
                                              input logic overflow,
                                              input logic busy,
                                              input logic full,
                                              input logic empty);
    logic [31:0] s;
    s             = '0;
    s[STAT_IRQ]   = irq_pend;
    s[STAT_OVF]   = overflow;
    s[STAT_BUSY]  = busy;
    s[STAT_FULL]  = full;
    s[STAT_EMPTY] = empty;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tx_fifo: synchronous FIFO with occupancy counter, combinational head output
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the pre-edge count, so a push into a full queue is
  // refused even when a pop happens on the same edge.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_port.sv
// ---------------------------------------------------------------------------
// uart_tx_port: bus-mapped 8N1 UART transmitter with TX queue and done irq
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx_port
  import uart_tx_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 5208,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] DATA_ADDR    = DEFAULT_DATA_ADDR,
  parameter logic [31:0] STAT_ADDR    = DEFAULT_STAT_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  tx_state_e   state;
  tx_state_e   state_next;
  logic [CW-1:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic [7:0]  shift_next;
  logic        tx_next;
  logic        irq_pend;
  logic        overflow;
  logic        bit_end;
  logic        pop;
  logic        data_wr;
  logic        stat_wr;
  logic        stat_rd;
  logic        irq_set;
  logic        busy;
  logic [7:0]  fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;
  logic        unused_wdata;

  assign data_wr      = wr && (addr == DATA_ADDR);
  assign stat_wr      = wr && (addr == STAT_ADDR);
  assign stat_rd      = rd && (addr == STAT_ADDR);
  assign unused_wdata = ^wdata[31:8];

  assign busy    = (state != IDLE);
  assign bit_end = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign irq_set = (state == STOP) && bit_end && fifo_empty;
  assign irq     = irq_pend;
  assign rdata   = stat_rd ? pack_status(irq_pend, overflow, busy, fifo_full, fifo_empty)
                           : '0;

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (data_wr),
    .din   (wdata[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty) state_next = START;
      START:   if (bit_end) state_next = DATA;
      DATA:    if (bit_end && (bit_cnt == 3'd7)) state_next = STOP;
      STOP:    if (bit_end) state_next = fifo_empty ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  // tx_next looks at the state being entered so the registered line changes
  // on the same edge as the FSM, keeping frames exactly 10 bit times.
  always_comb begin
    pop        = 1'b0;
    shift_next = shift;
    case (state)
      IDLE:    pop = !fifo_empty;
      STOP:    pop = bit_end && !fifo_empty;
      default: pop = 1'b0;
    endcase
    if (pop)                           shift_next = fifo_dout;
    else if ((state == DATA) && bit_end) shift_next = {1'b0, shift[7:1]};
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      irq_pend <= 1'b0;
      overflow <= 1'b0;
    end else begin
      baud_cnt <= ((state == IDLE) || bit_end) ? '0 : baud_cnt + 1'b1;
      if (pop)                             bit_cnt <= '0;
      else if ((state == DATA) && bit_end) bit_cnt <= bit_cnt + 3'd1;
      shift <= shift_next;
      tx    <= tx_next;
      // Set events take priority over a software clear on the same edge.
      if (irq_set)                   irq_pend <= 1'b1;
      else if (stat_wr && wdata[0])  irq_pend <= 1'b0;
      if (data_wr && fifo_full)      overflow <= 1'b1;
      else if (stat_wr && wdata[1])  overflow <= 1'b0;
    end
  end

endmodule

`default_nettype wire
